// File: rtl/gpio_ext.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_ext
//  Description : BW-pin GPIO bank on the ic0 slave bus with set/clear/toggle
//                control, open-drain pads and edge-triggered W1C interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_ext #(
    parameter int unsigned BW          = 8,
    parameter logic [31:0] BASE        = 32'h0000_0440,
    parameter logic [31:0] OFFSET      = 32'h0000_0040 * 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    inout  wire  [BW-1:0] b0_data_io,
    input  logic          ic0_c_axi_mst_wr_valid,
    input  logic [31:0]   ic0_axi_mst_wr_addr,
    input  logic [31:0]   ic0_axi_mst_wr_data,
    input  logic          ic0_c_axi_mst_rd_valid,
    input  logic [31:0]   ic0_axi_mst_rd_addr,
    output logic          ic0_c_axi_slv_rd_ready_0,
    output logic [31:0]   ic0_axi_slv_rd_data_0,
    output logic          irq
);

    localparam logic [31:0] c_WIN     = BASE + OFFSET;
    localparam logic [5:0]  c_WIN_IDX = c_WIN[11:6];
    localparam logic [2:0]  c_WARM    = 3'(SYNC_STAGES + 1);

    localparam logic [5:0] c_OFF_DIR_CLR  = 6'h00;
    localparam logic [5:0] c_OFF_DIR_SET  = 6'h04;
    localparam logic [5:0] c_OFF_TRI_CLR  = 6'h08;
    localparam logic [5:0] c_OFF_TRI_SET  = 6'h0C;
    localparam logic [5:0] c_OFF_OUT_CLR  = 6'h10;
    localparam logic [5:0] c_OFF_OUT_SET  = 6'h14;
    localparam logic [5:0] c_OFF_OUT_TGL  = 6'h18;
    localparam logic [5:0] c_OFF_IRQ_EN   = 6'h1C;
    localparam logic [5:0] c_OFF_DATA_IN  = 6'h20;
    localparam logic [5:0] c_OFF_IRQ_STAT = 6'h24;
    localparam logic [5:0] c_OFF_RISE_EN  = 6'h28;
    localparam logic [5:0] c_OFF_FALL_EN  = 6'h2C;
    localparam logic [5:0] c_OFF_DIR      = 6'h30;
    localparam logic [5:0] c_OFF_TRI      = 6'h34;
    localparam logic [5:0] c_OFF_OUT      = 6'h38;

    // Write pipeline stage
    logic          r_wr_v_q;
    logic [5:0]    r_wr_off_q;
    logic [BW-1:0] r_wr_data_q;

    // Architectural registers and their next-state values
    logic [BW-1:0] r_dir_q,      r_dir_d;
    logic [BW-1:0] r_tri_q,      r_tri_d;
    logic [BW-1:0] r_out_q,      r_out_d;
    logic [BW-1:0] r_irq_en_q,   r_irq_en_d;
    logic [BW-1:0] r_rise_en_q,  r_rise_en_d;
    logic [BW-1:0] r_fall_en_q,  r_fall_en_d;
    logic [BW-1:0] r_irq_stat_q, r_irq_stat_d;

    // Input path
    logic [BW-1:0] r_sync_q [SYNC_STAGES];
    logic [BW-1:0] r_prev_q;
    logic [BW-1:0] r_data_in_q;
    logic [2:0]    r_warm_q;

    // Read port and interrupt
    logic          r_rd_ready_q;
    logic [31:0]   r_rd_data_q;
    logic          r_irq_q;

    logic          w_wr_hit;
    logic          w_rd_hit;
    logic [BW-1:0] w_sync;
    logic [BW-1:0] w_rise;
    logic [BW-1:0] w_fall;
    logic [BW-1:0] w_edge_set;
    logic [BW-1:0] w_w1c;
    logic [BW-1:0] w_oe;
    logic [31:0]   w_rd_mux;
    logic          w_unused_addr;

    assign w_wr_hit = ic0_c_axi_mst_wr_valid && (ic0_axi_mst_wr_addr[11:6] == c_WIN_IDX);
    assign w_rd_hit = ic0_c_axi_mst_rd_valid && (ic0_axi_mst_rd_addr[11:6] == c_WIN_IDX);

    assign w_unused_addr = ^{ic0_axi_mst_wr_addr[31:12], ic0_axi_mst_rd_addr[31:12]};

    generate
        if (BW < 32) begin : g_unused_data
            logic w_unused_data;
            assign w_unused_data = ^ic0_axi_mst_wr_data[31:BW];
        end
    endgenerate

    // Edge detection stays gated until the synchroniser has flushed its reset zeros
    assign w_sync     = r_sync_q[SYNC_STAGES-1];
    assign w_rise     = w_sync & ~r_prev_q & r_rise_en_q;
    assign w_fall     = ~w_sync & r_prev_q & r_fall_en_q;
    assign w_edge_set = (r_warm_q == 3'd0) ? (w_rise | w_fall) : '0;

    always_comb begin
        r_dir_d     = r_dir_q;
        r_tri_d     = r_tri_q;
        r_out_d     = r_out_q;
        r_irq_en_d  = r_irq_en_q;
        r_rise_en_d = r_rise_en_q;
        r_fall_en_d = r_fall_en_q;
        w_w1c       = '0;
        if (r_wr_v_q) begin
            case (r_wr_off_q)
                c_OFF_DIR_CLR:  r_dir_d     = r_dir_q & ~r_wr_data_q;
                c_OFF_DIR_SET:  r_dir_d     = r_dir_q | r_wr_data_q;
                c_OFF_TRI_CLR:  r_tri_d     = r_tri_q & ~r_wr_data_q;
                c_OFF_TRI_SET:  r_tri_d     = r_tri_q | r_wr_data_q;
                c_OFF_OUT_CLR:  r_out_d     = r_out_q & ~r_wr_data_q;
                c_OFF_OUT_SET:  r_out_d     = r_out_q | r_wr_data_q;
                c_OFF_OUT_TGL:  r_out_d     = r_out_q ^ r_wr_data_q;
                c_OFF_IRQ_EN:   r_irq_en_d  = r_wr_data_q;
                c_OFF_IRQ_STAT: w_w1c       = r_wr_data_q;
                c_OFF_RISE_EN:  r_rise_en_d = r_wr_data_q;
                c_OFF_FALL_EN:  r_fall_en_d = r_wr_data_q;
                default: ;
            endcase
        end
        // A fresh edge outranks a simultaneous W1C on the same bit
        r_irq_stat_d = (r_irq_stat_q & ~w_w1c) | w_edge_set;
    end

    always_comb begin
        w_rd_mux = '0;
        case (ic0_axi_mst_rd_addr[5:0])
            c_OFF_IRQ_EN:   w_rd_mux[BW-1:0] = r_irq_en_q;
            c_OFF_DATA_IN:  w_rd_mux[BW-1:0] = r_data_in_q;
            c_OFF_IRQ_STAT: w_rd_mux[BW-1:0] = r_irq_stat_q;
            c_OFF_RISE_EN:  w_rd_mux[BW-1:0] = r_rise_en_q;
            c_OFF_FALL_EN:  w_rd_mux[BW-1:0] = r_fall_en_q;
            c_OFF_DIR:      w_rd_mux[BW-1:0] = r_dir_q;
            c_OFF_TRI:      w_rd_mux[BW-1:0] = r_tri_q;
            c_OFF_OUT:      w_rd_mux[BW-1:0] = r_out_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_v_q     <= 1'b0;
            r_wr_off_q   <= '0;
            r_wr_data_q  <= '0;
            r_dir_q      <= '0;
            r_tri_q      <= '0;
            r_out_q      <= '0;
            r_irq_en_q   <= '0;
            r_rise_en_q  <= '0;
            r_fall_en_q  <= '0;
            r_irq_stat_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= '0;
            end
            r_prev_q     <= '0;
            r_data_in_q  <= '0;
            r_warm_q     <= c_WARM;
            r_rd_ready_q <= 1'b0;
            r_rd_data_q  <= '0;
            r_irq_q      <= 1'b0;
        end else begin
            r_wr_v_q     <= w_wr_hit;
            r_wr_off_q   <= ic0_axi_mst_wr_addr[5:0];
            r_wr_data_q  <= ic0_axi_mst_wr_data[BW-1:0];
            r_dir_q      <= r_dir_d;
            r_tri_q      <= r_tri_d;
            r_out_q      <= r_out_d;
            r_irq_en_q   <= r_irq_en_d;
            r_rise_en_q  <= r_rise_en_d;
            r_fall_en_q  <= r_fall_en_d;
            r_irq_stat_q <= r_irq_stat_d;
            r_sync_q[0]  <= b0_data_io;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= r_sync_q[i-1];
            end
            r_prev_q     <= w_sync;
            r_data_in_q  <= w_sync;
            if (r_warm_q != 3'd0) begin
                r_warm_q <= r_warm_q - 3'd1;
            end
            r_rd_ready_q <= w_rd_hit;
            r_rd_data_q  <= w_rd_hit ? w_rd_mux : 32'd0;
            r_irq_q      <= |(r_irq_stat_q & r_irq_en_q);
        end
    end

    // Open-drain pins only drive when the output bit is low
    generate
        for (genvar b = 0; b < BW; b++) begin : g_pad
            assign w_oe[b]       = r_dir_q[b] & (~r_tri_q[b] | ~r_out_q[b]);
            assign b0_data_io[b] = w_oe[b] ? (r_out_q[b] & ~r_tri_q[b]) : 1'bz;
        end
    endgenerate

    assign ic0_c_axi_slv_rd_ready_0 = r_rd_ready_q;
    assign ic0_axi_slv_rd_data_0    = r_rd_data_q;
    assign irq                      = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_ext
//  Description : Directed vector table plus timing sequences for gpio_ext.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ext;

    localparam logic [31:0] c_A   = 32'h0000_0440;
    localparam logic [31:0] c_OOW = 32'h0000_0480;

    localparam logic [2:0] OP_WR  = 3'd0;
    localparam logic [2:0] OP_RD  = 3'd1;
    localparam logic [2:0] OP_PAD = 3'd2;
    localparam logic [2:0] OP_DRV = 3'd3;
    localparam logic [2:0] OP_RDX = 3'd4;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    wire  [7:0]  pads;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        irq;
    logic [7:0]  drv_en;
    logic [7:0]  drv_val;

    int   n_checks;
    int   n_err;
    vec_t vecs[$];

    gpio_ext #(
        .BW          (8),
        .BASE        (32'h0000_0440),
        .OFFSET      (32'h0000_0000),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .b0_data_io               (pads),
        .ic0_c_axi_mst_wr_valid   (wr_valid),
        .ic0_axi_mst_wr_addr      (wr_addr),
        .ic0_axi_mst_wr_data      (wr_data),
        .ic0_c_axi_mst_rd_valid   (rd_valid),
        .ic0_axi_mst_rd_addr      (rd_addr),
        .ic0_c_axi_slv_rd_ready_0 (rd_ready),
        .ic0_axi_slv_rd_data_0    (rd_data),
        .irq                      (irq)
    );

    // External pull-ups let a released pad read as 1
    generate
        for (genvar i = 0; i < 8; i++) begin : g_tb_pad
            assign pads[i] = drv_en[i] ? drv_val[i] : 1'bz;
            pullup (pads[i]);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        @(negedge clk);
        rd_valid = 1'b0;
        check({name, "_ready"}, {31'd0, rd_ready}, 32'd1);
        check({name, "_data"}, rd_data, exp);
        @(negedge clk);
        check({name, "_ready_drop"}, {31'd0, rd_ready}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.op   = op;
        v.addr = a;
        v.data = d;
        v.exp  = e;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        drv_en   = '0;
        drv_val  = '0;

        vecs.push_back(mk(OP_RD,  c_A + 32'h30, 0, 32'h00));
        vecs.push_back(mk(OP_RD,  c_A + 32'h34, 0, 32'h00));
        vecs.push_back(mk(OP_RD,  c_A + 32'h38, 0, 32'h00));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFF));
        vecs.push_back(mk(OP_WR,  c_A + 32'h04, 32'hFF, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'h00));
        vecs.push_back(mk(OP_WR,  c_A + 32'h14, 32'hA5, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hA5));
        vecs.push_back(mk(OP_WR,  c_A + 32'h18, 32'h0F, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hAA));
        vecs.push_back(mk(OP_RD,  c_A + 32'h38, 0, 32'hAA));
        vecs.push_back(mk(OP_RD,  c_A + 32'h30, 0, 32'hFF));
        vecs.push_back(mk(OP_WR,  c_A + 32'h10, 32'hFF, 0));
        vecs.push_back(mk(OP_WR,  c_A + 32'h14, 32'h1FF, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h38, 0, 32'hFF));
        vecs.push_back(mk(OP_RD,  c_A + 32'h00, 0, 32'h00));
        vecs.push_back(mk(OP_RD,  c_A + 32'h14, 0, 32'h00));
        vecs.push_back(mk(OP_RD,  c_A + 32'h3C, 0, 32'h00));
        vecs.push_back(mk(OP_WR,  c_A + 32'h1C, 32'h1FF, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h1C, 0, 32'hFF));
        vecs.push_back(mk(OP_WR,  c_A + 32'h1C, 32'h00, 0));
        vecs.push_back(mk(OP_RDX, c_OOW + 32'h38, 0, 0));
        vecs.push_back(mk(OP_WR,  c_OOW + 32'h10, 32'hFF, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h38, 0, 32'hFF));
        vecs.push_back(mk(OP_WR,  c_A + 32'h0C, 32'h01, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h34, 0, 32'h01));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFF));
        vecs.push_back(mk(OP_DRV, 32'h01, 32'h00, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFE));
        vecs.push_back(mk(OP_RD,  c_A + 32'h20, 0, 32'hFE));
        vecs.push_back(mk(OP_DRV, 32'h00, 32'h00, 0));
        vecs.push_back(mk(OP_WR,  c_A + 32'h10, 32'h03, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFC));
        vecs.push_back(mk(OP_WR,  c_A + 32'h14, 32'h02, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFE));
        vecs.push_back(mk(OP_WR,  c_A + 32'h14, 32'h01, 0));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFF));
        vecs.push_back(mk(OP_WR,  c_A + 32'h08, 32'h01, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h34, 0, 32'h00));
        vecs.push_back(mk(OP_WR,  c_A + 32'h00, 32'hFF, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h30, 0, 32'h00));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'hFF));
        vecs.push_back(mk(OP_DRV, 32'hFF, 32'h3C, 0));
        vecs.push_back(mk(OP_RD,  c_A + 32'h20, 0, 32'h3C));
        vecs.push_back(mk(OP_PAD, 0, 0, 32'h3C));
        vecs.push_back(mk(OP_DRV, 32'h00, 32'h00, 0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_ready", {31'd0, rd_ready}, 32'd0);
        check("reset_rdata", rd_data, 32'd0);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OP_WR:  bus_wr(vecs[i].addr, vecs[i].data);
                OP_RD:  bus_rd(nm, vecs[i].addr, vecs[i].exp);
                OP_PAD: begin
                    @(negedge clk);
                    check({nm, "_pads"}, {24'd0, pads}, vecs[i].exp);
                end
                OP_DRV: begin
                    drv_en  = vecs[i].addr[7:0];
                    drv_val = vecs[i].data[7:0];
                    repeat (5) @(negedge clk);
                end
                default: begin
                    @(negedge clk);
                    rd_valid = 1'b1;
                    rd_addr  = vecs[i].addr;
                    @(negedge clk);
                    rd_valid = 1'b0;
                    check({nm, "_oow_ready"}, {31'd0, rd_ready}, 32'd0);
                    check({nm, "_oow_data"}, rd_data, 32'd0);
                end
            endcase
        end

        // Edge interrupt latency and W1C behaviour
        drv_en  = 8'h03;
        drv_val = 8'h02;
        repeat (5) @(negedge clk);
        bus_wr(c_A + 32'h28, 32'h01);
        bus_wr(c_A + 32'h2C, 32'h02);
        bus_wr(c_A + 32'h1C, 32'h03);
        bus_rd("stat_idle", c_A + 32'h24, 32'h00);
        @(negedge clk);
        drv_val = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("irq_lat%0d", k), {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
        end
        bus_rd("stat_both", c_A + 32'h24, 32'h03);
        bus_wr(c_A + 32'h24, 32'h01);
        check("irq_after_w1c0", {31'd0, irq}, 32'd1);
        bus_rd("stat_after_w1c0", c_A + 32'h24, 32'h02);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = c_A + 32'h24;
        wr_data  = 32'h02;
        @(negedge clk);
        wr_valid = 1'b0;
        check("irq_w1c_n1", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_w1c_n2", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_w1c_n3", {31'd0, irq}, 32'd0);
        bus_rd("stat_cleared", c_A + 32'h24, 32'h00);

        // W1C lands on the same edge that a new rising edge sets bit 0
        drv_val = 8'h00;
        repeat (5) @(negedge clk);
        bus_rd("stat_pre_race", c_A + 32'h24, 32'h00);
        @(negedge clk);
        drv_val = 8'h01;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = c_A + 32'h24;
        wr_data  = 32'h01;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        bus_rd("stat_race", c_A + 32'h24, 32'h01);
        check("irq_race", {31'd0, irq}, 32'd1);
        bus_wr(c_A + 32'h24, 32'h01);
        bus_rd("stat_race_clr", c_A + 32'h24, 32'h00);

        // Pins high through reset release must not look like rising edges
        drv_en  = 8'hFF;
        drv_val = 8'hFF;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = c_A + 32'h28;
        wr_data  = 32'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = c_A + 32'h20;
        @(negedge clk);
        check("din_early_ready", {31'd0, rd_ready}, 32'd1);
        check("din_early", rd_data, 32'h00);
        @(negedge clk);
        rd_valid = 1'b0;
        check("din_settled", rd_data, 32'hFF);
        repeat (5) @(negedge clk);
        bus_rd("warm_stat", c_A + 32'h24, 32'h00);
        bus_rd("warm_rise_en", c_A + 32'h28, 32'hFF);
        bus_rd("warm_irq_en", c_A + 32'h1C, 32'h00);
        check("warm_irq", {31'd0, irq}, 32'd0);

        // Reset one cycle after a write valid
        drv_en = 8'h00;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = c_A + 32'h14;
        wr_data  = 32'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd("rst_mid_wr_out", c_A + 32'h38, 32'h00);

        // Write valid presented while reset is asserted
        @(negedge clk);
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = c_A + 32'h14;
        wr_data  = 32'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd("rst_same_wr_out", c_A + 32'h38, 32'h00);
        @(negedge clk);
        check("final_pads", {24'd0, pads}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
